// File: rtl/aes_pkg.sv
// aes_pkg: shared AES datapath constants and types.
//   AES_STATE_W  - width of one AES state / round key (128)
//   AES_WORD_W   - width of one AES column word (32)
//   round_key_t  - one expanded round key; banks are unpacked arrays of these
//   aes_beats()  - number of LANE_W-bit beats needed to carry one state
package aes_pkg;

    localparam int unsigned AES_STATE_W = 128;
    localparam int unsigned AES_WORD_W  = 32;

    typedef logic [AES_STATE_W-1:0] round_key_t;

    function automatic int unsigned aes_beats(input int unsigned lane_w);
        return AES_STATE_W / lane_w;
    endfunction

endpackage

// File: rtl/round_key_bank.sv
// round_key_bank: NUM_KEYS x 128-bit round-key register file.
//   clk, rst_n    - clock, async active-low reset (bank clears to zero)
//   wr_en_i       - write wr_data_i into slot wr_idx_i this cycle
//   wr_idx_i      - slot to write (out-of-range writes are ignored)
//   wr_data_i     - round key, word 0 in bits [31:0]
//   rd_idx_i      - slot to read
//   rd_beat_i     - which LANE_W slice of the key to return
//   rd_slice_o    - key[LANE_W*beat +: LANE_W]; zero for an out-of-range slot
module round_key_bank
    import aes_pkg::*;
#(
    parameter int unsigned LANE_W   = 32,
    parameter int unsigned NUM_KEYS = 11,
    parameter int unsigned IDX_W    = $clog2(NUM_KEYS),
    parameter int unsigned BEAT_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  round_key_t        wr_data_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    input  logic [BEAT_W-1:0] rd_beat_i,
    output logic [LANE_W-1:0] rd_slice_o
);

    round_key_t keys_q [NUM_KEYS];
    round_key_t rd_key;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                keys_q[i] <= '0;
            end
        end else if (wr_en_i && (32'(wr_idx_i) < NUM_KEYS)) begin
            keys_q[wr_idx_i] <= wr_data_i;
        end
    end

    // A shift rather than an indexed part-select keeps the single-beat
    // (LANE_W = 128) configuration free of out-of-range select warnings.
    always_comb begin
        rd_key = '0;
        if (32'(rd_idx_i) < NUM_KEYS) begin
            rd_key = keys_q[rd_idx_i];
        end
        rd_slice_o = LANE_W'(rd_key >> (LANE_W * 32'(rd_beat_i)));
    end

endmodule

// File: rtl/add_round_key_stream.sv
// add_round_key_stream: streaming AddRoundKey engine.
//   clk, rst_n                       - clock, async active-low reset
//   key_wr_en/key_wr_idx/key_wr_data - round-key bank write port
//   s_valid/s_ready/s_data/s_round   - input beats; s_round sampled on beat 0
//   m_valid/m_ready/m_data           - registered output beats (state ^ key)
//   m_last                           - final beat of a state
//   m_err                            - every beat of a state with index >= NUM_KEYS
module add_round_key_stream
    import aes_pkg::*;
#(
    parameter int unsigned LANE_W     = 32,
    parameter int unsigned NUM_KEYS   = 11,
    parameter int unsigned AUTO_ROUND = 0,
    localparam int unsigned IDX_W     = $clog2(NUM_KEYS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_wr_en,
    input  logic [IDX_W-1:0]  key_wr_idx,
    input  logic [127:0]      key_wr_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [LANE_W-1:0] s_data,
    input  logic [IDX_W-1:0]  s_round,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [LANE_W-1:0] m_data,
    output logic              m_last,
    output logic              m_err
);

    localparam int unsigned BEATS  = aes_beats(LANE_W);
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic {ST_FIRST, ST_BODY} beat_state_e;

    beat_state_e       state_q;
    logic [BEAT_W-1:0] beat_q;
    logic [IDX_W-1:0]  round_q;
    logic [IDX_W-1:0]  auto_q;
    logic              m_valid_q;
    logic [LANE_W-1:0] m_data_q;
    logic              m_last_q;
    logic              m_err_q;

    logic              accept;
    logic [IDX_W-1:0]  cur_idx;
    logic [BEAT_W-1:0] cur_beat;
    logic              cur_last;
    logic              cur_err;
    logic [LANE_W-1:0] key_slice;

    assign s_ready = !m_valid_q || m_ready;
    assign accept  = s_valid && s_ready;

    // Beat 0 reads the live index; later beats reuse the one latched on beat 0.
    always_comb begin
        cur_idx  = round_q;
        cur_beat = beat_q;
        if (state_q == ST_FIRST) begin
            cur_idx  = (AUTO_ROUND != 0) ? auto_q : s_round;
            cur_beat = '0;
        end
    end

    assign cur_last = (cur_beat == LAST_BEAT);
    assign cur_err  = (AUTO_ROUND == 0) && (32'(cur_idx) >= NUM_KEYS);

    round_key_bank #(
        .LANE_W   (LANE_W),
        .NUM_KEYS (NUM_KEYS),
        .IDX_W    (IDX_W),
        .BEAT_W   (BEAT_W)
    ) u_bank (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en_i    (key_wr_en),
        .wr_idx_i   (key_wr_idx),
        .wr_data_i  (key_wr_data),
        .rd_idx_i   (cur_idx),
        .rd_beat_i  (cur_beat),
        .rd_slice_o (key_slice)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FIRST;
            beat_q    <= '0;
            round_q   <= '0;
            auto_q    <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            m_err_q   <= 1'b0;
        end else begin
            if (accept) begin
                m_valid_q <= 1'b1;
                m_data_q  <= s_data ^ key_slice;
                m_last_q  <= cur_last;
                m_err_q   <= cur_err;
            end else if (m_ready) begin
                m_valid_q <= 1'b0;
            end

            if (accept) begin
                case (state_q)
                    ST_FIRST: begin
                        round_q <= cur_idx;
                        if (BEATS > 1) begin
                            state_q <= ST_BODY;
                            beat_q  <= BEAT_W'(1);
                        end
                    end
                    ST_BODY: beat_q <= beat_q + 1'b1;
                    default: state_q <= ST_FIRST;
                endcase
                // Completing a state overrides the transitions above, which also
                // covers the single-beat case where FIRST is never left.
                if (cur_last) begin
                    state_q <= ST_FIRST;
                    beat_q  <= '0;
                    if (AUTO_ROUND != 0) begin
                        auto_q <= (auto_q == IDX_W'(NUM_KEYS - 1)) ? '0 : auto_q + 1'b1;
                    end
                end
            end
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_last  = m_last_q;
    assign m_err   = m_err_q;

endmodule

// File: tb/tb_add_round_key_stream.sv
module tb_add_round_key_stream;

    localparam logic [127:0] FIPS_K = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    localparam logic [127:0] FIPS_S = 128'hffeeddcc_bbaa9988_77665544_33221100;
    localparam logic [127:0] FIPS_R = 128'hf0e0d0c0_b0a09080_70605040_30201000;

    logic clk;
    logic rst_n;

    // Instance A: LANE_W=32, explicit s_round (scoreboarded)
    logic         a_key_wr_en;
    logic [3:0]   a_key_wr_idx;
    logic [127:0] a_key_wr_data;
    logic         a_s_valid, a_s_ready;
    logic [31:0]  a_s_data;
    logic [3:0]   a_s_round;
    logic         a_m_valid, a_m_ready, a_m_last, a_m_err;
    logic [31:0]  a_m_data;

    // Instance B: LANE_W=128
    logic         b_key_wr_en;
    logic [3:0]   b_key_wr_idx;
    logic [127:0] b_key_wr_data;
    logic         b_s_valid, b_s_ready;
    logic [127:0] b_s_data;
    logic [3:0]   b_s_round;
    logic         b_m_valid, b_m_ready, b_m_last, b_m_err;
    logic [127:0] b_m_data;

    // Instance C: LANE_W=32, AUTO_ROUND=1
    logic         c_key_wr_en;
    logic [3:0]   c_key_wr_idx;
    logic [127:0] c_key_wr_data;
    logic         c_s_valid, c_s_ready;
    logic [31:0]  c_s_data;
    logic [3:0]   c_s_round;
    logic         c_m_valid, c_m_ready, c_m_last, c_m_err;
    logic [31:0]  c_m_data;

    add_round_key_stream #(.LANE_W(32), .NUM_KEYS(11), .AUTO_ROUND(0)) u_a (
        .clk(clk), .rst_n(rst_n),
        .key_wr_en(a_key_wr_en), .key_wr_idx(a_key_wr_idx), .key_wr_data(a_key_wr_data),
        .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data), .s_round(a_s_round),
        .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data),
        .m_last(a_m_last), .m_err(a_m_err)
    );

    add_round_key_stream #(.LANE_W(128), .NUM_KEYS(11), .AUTO_ROUND(0)) u_b (
        .clk(clk), .rst_n(rst_n),
        .key_wr_en(b_key_wr_en), .key_wr_idx(b_key_wr_idx), .key_wr_data(b_key_wr_data),
        .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data), .s_round(b_s_round),
        .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data),
        .m_last(b_m_last), .m_err(b_m_err)
    );

    add_round_key_stream #(.LANE_W(32), .NUM_KEYS(11), .AUTO_ROUND(1)) u_c (
        .clk(clk), .rst_n(rst_n),
        .key_wr_en(c_key_wr_en), .key_wr_idx(c_key_wr_idx), .key_wr_data(c_key_wr_data),
        .s_valid(c_s_valid), .s_ready(c_s_ready), .s_data(c_s_data), .s_round(c_s_round),
        .m_valid(c_m_valid), .m_ready(c_m_ready), .m_data(c_m_data),
        .m_last(c_m_last), .m_err(c_m_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // ---------------- reference model for instance A ----------------
    logic [127:0] kmodel [11];
    logic [31:0]  q_d [$];
    logic         q_l [$];
    logic         q_e [$];
    logic [31:0]  obs [$];

    // Whole-state view: result = state ^ key (zero key when out of range),
    // then cut into 32-bit words, word 0 first.
    task automatic push_state(input logic [127:0] st, input int r);
        logic [127:0] k;
        logic [127:0] res;
        k   = (r < 11) ? kmodel[r] : '0;
        res = st ^ k;
        for (int b = 0; b < 4; b++) begin
            q_d.push_back(res[32*b +: 32]);
            q_l.push_back(b == 3);
            q_e.push_back(r >= 11);
        end
    endtask

    logic sb_en    = 1'b0;
    logic rand_rdy = 1'b0;

    initial begin
        a_m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            a_m_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    logic        stall_pend = 1'b0;
    logic [31:0] hold_d;
    logic        hold_l, hold_e;

    always @(negedge clk) begin
        if (sb_en && rst_n) begin
            if (stall_pend) begin
                chk("stall_data", a_m_data, hold_d);
                chk("stall_last", a_m_last, hold_l);
                chk("stall_err",  a_m_err,  hold_e);
            end
            stall_pend = a_m_valid && !a_m_ready;
            hold_d = a_m_data;
            hold_l = a_m_last;
            hold_e = a_m_err;
            chk("s_ready_rule", a_s_ready, !a_m_valid || a_m_ready);
            if (a_m_valid && a_m_ready) begin
                if (q_d.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_beat actual=%h required=no_beat", a_m_data);
                end else begin
                    chk("beat_data", a_m_data, q_d.pop_front());
                    chk("beat_last", a_m_last, q_l.pop_front());
                    chk("beat_err",  a_m_err,  q_e.pop_front());
                    obs.push_back(a_m_data);
                end
            end
        end else begin
            stall_pend = 1'b0;
        end
    end

    // ---------------- instance A drivers (called at posedge+1) ----------------
    task automatic write_key_a(input int idx, input logic [127:0] data);
        a_key_wr_en   = 1'b1;
        a_key_wr_idx  = 4'(idx);
        a_key_wr_data = data;
        @(posedge clk);
        #1;
        a_key_wr_en = 1'b0;
        kmodel[idx] = data;
    endtask

    task automatic send_state(input logic [127:0] st, input logic [3:0] r);
        logic acc;
        int   n;
        push_state(st, int'(r));
        for (int b = 0; b < 4; b++) begin
            a_s_valid = 1'b1;
            a_s_data  = st[32*b +: 32];
            a_s_round = (b == 0) ? r : 4'($urandom_range(0, 15));
            acc = 1'b0;
            n   = 0;
            while (!acc) begin
                @(negedge clk);
                acc = a_s_ready;
                @(posedge clk);
                #1;
                n++;
                if (!acc && n > 1000) begin
                    failures++;
                    $display("FAIL accept_timeout actual=no_accept required=accept");
                    $fatal(1, "accept timeout");
                end
            end
        end
    endtask

    task automatic drain_a();
        int n;
        a_s_valid = 1'b0;
        n = 0;
        while (q_d.size() > 0 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        chk("drain_left", q_d.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [127:0] st;
        logic [31:0]  d;
        logic [31:0]  kw;

        rst_n = 1'b0;
        a_key_wr_en = 0; a_key_wr_idx = 0; a_key_wr_data = '0;
        a_s_valid = 0; a_s_data = '0; a_s_round = 0;
        b_key_wr_en = 0; b_key_wr_idx = 0; b_key_wr_data = '0;
        b_s_valid = 0; b_s_data = '0; b_s_round = 0; b_m_ready = 1'b1;
        c_key_wr_en = 0; c_key_wr_idx = 0; c_key_wr_data = '0;
        c_s_valid = 0; c_s_data = '0; c_s_round = 0; c_m_ready = 1'b1;
        for (int k = 0; k < 11; k++) kmodel[k] = '0;

        repeat (2) @(negedge clk);
        chk("rst_a_s_ready", a_s_ready, 1'b1);
        chk("rst_a_m_valid", a_m_valid, 1'b0);
        chk("rst_a_m_data",  a_m_data,  32'h0);
        chk("rst_a_m_last",  a_m_last,  1'b0);
        chk("rst_a_m_err",   a_m_err,   1'b0);
        chk("rst_b_s_ready", b_s_ready, 1'b1);
        chk("rst_b_m_valid", b_m_valid, 1'b0);
        chk("rst_c_m_valid", c_m_valid, 1'b0);

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb_en = 1'b1;

        // Keys for B (FIPS key in slot 0) and C (slot k = byte k everywhere)
        @(negedge clk);
        for (int k = 0; k < 11; k++) begin
            c_key_wr_en   = 1'b1;
            c_key_wr_idx  = 4'(k);
            c_key_wr_data = {16{8'(k)}};
            b_key_wr_en   = (k == 0);
            b_key_wr_idx  = 4'd0;
            b_key_wr_data = FIPS_K;
            @(negedge clk);
        end
        c_key_wr_en = 1'b0;
        b_key_wr_en = 1'b0;

        // B: single 128-bit beat, one cycle latency
        b_s_valid = 1'b1;
        b_s_data  = FIPS_S;
        b_s_round = 4'd0;
        @(negedge clk);
        b_s_valid = 1'b0;
        chk("b_fips_valid", b_m_valid, 1'b1);
        chk("b_fips_data",  b_m_data,  128'hf0e0d0c0_b0a09080_70605040_30201000);
        chk("b_fips_last",  b_m_last,  1'b1);
        chk("b_fips_err",   b_m_err,   1'b0);
        @(negedge clk);
        chk("b_idle_valid", b_m_valid, 1'b0);

        // C: auto round counter, 12 states -> keys 0..10 then 0
        for (int s = 0; s < 12; s++) begin
            for (int b = 0; b < 4; b++) begin
                d  = {8'(s), 8'(b), 16'hc35a};
                kw = {4{8'(s % 11)}};
                c_s_valid = 1'b1;
                c_s_data  = d;
                c_s_round = 4'hf;
                @(negedge clk);
                chk("c_valid", c_m_valid, 1'b1);
                chk("c_data",  c_m_data,  d ^ kw);
                chk("c_last",  c_m_last,  b == 3);
                chk("c_err",   c_m_err,   1'b0);
            end
        end
        c_s_valid = 1'b0;

        // A: FIPS-197 round 0 with literal expectations
        @(posedge clk);
        #1;
        write_key_a(0, FIPS_K);
        obs.delete();
        send_state(FIPS_S, 4'd0);
        drain_a();
        chk("fips_nbeats", obs.size(), 4);
        chk("fips_beat0", obs[0], 32'h30201000);
        chk("fips_beat1", obs[1], 32'h70605040);
        chk("fips_beat2", obs[2], 32'hb0a09080);
        chk("fips_beat3", obs[3], 32'hf0e0d0c0);

        // A: out-of-range index passes data through with m_err, then a normal state
        obs.delete();
        send_state(FIPS_S, 4'd11);
        send_state(FIPS_S, 4'd0);
        drain_a();
        chk("oor_pass0", obs[0], 32'h33221100);
        chk("oor_next0", obs[4], 32'h30201000);

        // A: random keys, 100 back-to-back states under random backpressure
        for (int k = 0; k < 11; k++)
            write_key_a(k, {$urandom, $urandom, $urandom, $urandom});
        rand_rdy = 1'b1;
        for (int s = 0; s < 100; s++) begin
            st = {$urandom, $urandom, $urandom, $urandom};
            send_state(st, 4'($urandom_range(0, 10)));
        end
        drain_a();
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;

        // A: reset after beat 1 of a state
        sb_en = 1'b0;
        a_s_valid = 1'b1;
        a_s_data  = 32'h11111111;
        a_s_round = 4'd0;
        @(posedge clk);
        #1;
        a_s_data = 32'h22222222;
        @(posedge clk);
        #1;
        a_s_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_m_valid", a_m_valid, 1'b0);
        chk("midrst_m_data",  a_m_data,  32'h0);
        chk("midrst_m_last",  a_m_last,  1'b0);
        chk("midrst_m_err",   a_m_err,   1'b0);
        chk("midrst_s_ready", a_s_ready, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q_d.delete(); q_l.delete(); q_e.delete(); obs.delete();
        for (int k = 0; k < 11; k++) kmodel[k] = '0;
        sb_en = 1'b1;
        send_state(128'h0badf00d_cafebabe_deadbeef_12345678, 4'd0);
        drain_a();
        chk("post_rst_beat0", obs[0], 32'h12345678);
        chk("post_rst_beat3", obs[3], 32'h0badf00d);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
